// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: word width and the fetch queue entry.
package cpu_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Producer/consumer handshake bundle around the fetch queue.
interface fetch_queue_if;
    import cpu_pkg::*;

    logic            in_valid;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_instr;
    logic            in_ready;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic            out_ready;

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr
    );

endinterface

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one write port, one async read port.
module fetch_queue_mem
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  fetch_entry_t               wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output fetch_entry_t               rdata
);

    fetch_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Circular {pc, instr} buffer between ifetch and decode with redirect flush.
// FETCH_QUEUE_BYPASS_EN enables a zero-latency path when the queue is empty.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    fetch_queue_if.slave             bus,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW:0]   rd_ptr;
    logic [AW:0]   wr_ptr;
    logic [CW-1:0] count;

    fetch_entry_t wdata;
    fetch_entry_t rdata;
    fetch_entry_t hold;
    fetch_entry_t head;

    logic empty;
    logic push;
    logic pop;
    logic bypass;

    assign empty = (count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty & ~flush_i
                  & bus.in_valid & bus.out_ready;
`else
    assign bypass = 1'b0;
`endif

    // Ready depends only on registered occupancy, never on out_ready.
    assign bus.in_ready = (count < CW'(DEPTH));

    assign push = bus.in_valid & bus.in_ready & ~bypass;
    assign pop  = ~empty & bus.out_ready;

    assign wdata.pc    = bus.in_pc;
    assign wdata.instr = bus.in_instr;

    fetch_queue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~flush_i),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wdata),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    always_comb begin
        bus.out_valid = ~empty;
        head          = empty ? hold : rdata;
        if (bypass) begin
            bus.out_valid = 1'b1;
            head          = wdata;
        end
    end

    assign bus.out_pc    = head.pc;
    assign bus.out_instr = head.instr;
    assign count_o       = count;

    // hold keeps the last head so outputs are defined while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            hold   <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
            count <= count + CW'(push) - CW'(pop);
            if (!empty)
                hold <= rdata;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill/drain, wrap, full+pop, flush, bypass, reset.
module tb_fetch_queue;
    import cpu_pkg::*;

    logic       clk;
    logic       rst;
    logic       flush_i;
    logic [2:0] count_o;

    int n_cmp = 0;
    int n_err = 0;

    fetch_queue_if bus();

    fetch_queue #(
        .DEPTH (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_i),
        .bus     (bus),
        .count_o (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v,
                         input logic [31:0] pc,
                         input logic rdy);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = 32'h1000_0000 + pc;
        bus.out_ready = rdy;
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        #3;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_out_pc", 64'(bus.out_pc), 64'd0);
        chk("rst_out_instr", 64'(bus.out_instr), 64'd0);
        cyc();
        rst = 1'b0;
        cyc();

        // fill with out_ready=0
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 1'b0);
            chk("fill_in_ready", 64'(bus.in_ready), 64'd1);
            chk("fill_count", 64'(count_o), 64'(i));
            if (i > 0) begin
                chk("fill_head_valid", 64'(bus.out_valid), 64'd1);
                chk("fill_head_pc", 64'(bus.out_pc), 64'h0);
            end
            cyc();
        end
        drive(1'b1, 32'h10, 1'b0);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        chk("full_count", 64'(count_o), 64'd4);
        cyc();
        drive(1'b0, 32'h0, 1'b1);
        chk("push5_refused", 64'(count_o), 64'd4);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1);
            chk("drain_valid", 64'(bus.out_valid), 64'd1);
            chk("drain_pc", 64'(bus.out_pc), 64'(4 * i));
            chk("drain_instr", 64'(bus.out_instr),
                64'(32'h1000_0000 + 32'(4 * i)));
            cyc();
        end
        drive(1'b0, 32'h0, 1'b0);
        chk("drain_empty", 64'(bus.out_valid), 64'd0);
        chk("drain_count", 64'(count_o), 64'd0);

        // wrap: prime one entry, then 9 push+pop pairs, then final pop
        drive(1'b1, 32'h100, 1'b0);
        cyc();
        for (int k = 1; k < 10; k++) begin
            drive(1'b1, 32'(32'h100 + 4 * k), 1'b1);
            chk("wrap_count", 64'(count_o), 64'd1);
            chk("wrap_pc", 64'(bus.out_pc),
                64'(32'h100 + 4 * (k - 1)));
            cyc();
        end
        drive(1'b0, 32'h0, 1'b1);
        chk("wrap_count_last", 64'(count_o), 64'd1);
        chk("wrap_pc_last", 64'(bus.out_pc), 64'h124);
        cyc();
        drive(1'b0, 32'h0, 1'b0);
        chk("wrap_empty", 64'(count_o), 64'd0);

        // full + pop: push refused
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(32'h300 + 4 * i), 1'b0);
            cyc();
        end
        drive(1'b1, 32'h3F0, 1'b1);
        chk("fp_in_ready", 64'(bus.in_ready), 64'd0);
        chk("fp_head", 64'(bus.out_pc), 64'h300);
        cyc();
        drive(1'b0, 32'h0, 1'b1);
        chk("fp_count", 64'(count_o), 64'd3);
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1);
            chk("fp_drain_pc", 64'(bus.out_pc),
                64'(32'h300 + 4 * i));
            cyc();
        end
        drive(1'b0, 32'h0, 1'b0);
        chk("fp_empty", 64'(count_o), 64'd0);

        // flush with a concurrent push and pop
        drive(1'b1, 32'h20, 1'b0);
        cyc();
        drive(1'b1, 32'h24, 1'b0);
        cyc();
        drive(1'b1, 32'h40, 1'b1);
        chk("fl_pre_count", 64'(count_o), 64'd2);
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        chk("fl_count", 64'(count_o), 64'd0);
        chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
        drive(1'b1, 32'h50, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 1'b1);
        chk("fl_next_pc", 64'(bus.out_pc), 64'h50);
        chk("fl_next_count", 64'(count_o), 64'd1);
        cyc();
        drive(1'b0, 32'h0, 1'b0);
        chk("fl_drained", 64'(count_o), 64'd0);

        // bypass / one-cycle latency on an empty queue
        drive(1'b1, 32'h200, 1'b1);
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("bp_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_pc", 64'(bus.out_pc), 64'h200);
        chk("bp_count", 64'(count_o), 64'd0);
        cyc();
        drive(1'b0, 32'h0, 1'b1);
        chk("bp_after_count", 64'(count_o), 64'd0);
        chk("bp_after_valid", 64'(bus.out_valid), 64'd0);
`else
        chk("lat_valid0", 64'(bus.out_valid), 64'd0);
        cyc();
        drive(1'b0, 32'h0, 1'b1);
        chk("lat_valid1", 64'(bus.out_valid), 64'd1);
        chk("lat_pc", 64'(bus.out_pc), 64'h200);
        chk("lat_count", 64'(count_o), 64'd1);
        cyc();
        drive(1'b0, 32'h0, 1'b0);
        chk("lat_drained", 64'(count_o), 64'd0);
`endif

        // reset mid-stream at count 3
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(32'h400 + 4 * i), 1'b0);
            cyc();
        end
        drive(1'b0, 32'h0, 1'b0);
        chk("mr_pre_count", 64'(count_o), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mr_count", 64'(count_o), 64'd0);
        chk("mr_in_ready", 64'(bus.in_ready), 64'd1);
        #1;
        rst = 1'b0;
        drive(1'b1, 32'h500, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 1'b0);
        chk("mr_post_pc", 64'(bus.out_pc), 64'h500);
        chk("mr_post_count", 64'(count_o), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
